keypad_scan_lift: RTL and testbench

KEYPAD_SCAN_LIFT -- requirements
Module: keypad_scan_lift

---
 rtl/lift_pkg.sv | 38 +++
 rtl/sync2.sv | 26 ++
 rtl/keypad_scan_lift.sv | 142 ++++++++++++++
 tb/tb_keypad_scan_lift.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared types and constants for the lift-call keypad scanner.
// Holds the FSM state enum, keypad dimensions and row-decode helpers.
package lift_pkg;

    localparam int FLOOR_W  = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    localparam logic [NUM_ROWS-1:0] ROW_IDLE = '1;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        VALID,
        RELEASE
    } state_t;

    // Index of the lowest-numbered row pulled low (0 if none).
    function automatic logic [1:0] row_index(input logic [NUM_ROWS-1:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // True when more than one row is pulled low.
    function automatic logic multi_low(input logic [NUM_ROWS-1:0] r);
        int n;
        n = 0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!r[i]) n++;
        end
        return (n > 1);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs.
// Flops reset to RST_VAL so idle lines read as inactive during reset.
module sync2 #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_lift.sv
// 4x4 keypad scanner producing debounced floor requests on a valid/ready port.
// Define KEYPAD_MULTI_KEY_REJECT_EN to ignore presses with several rows low.
module keypad_scan_lift
    import lift_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [FLOOR_W-1:0]  floor,
    output logic                floor_valid,
    input  logic                floor_ready
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_SAT   = '1;

    state_t              state;
    state_t              state_n;
    logic [1:0]          c;
    logic [1:0]          c_n;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_n;
    logic [CW-1:0]       cnt_inc;
    logic [NUM_ROWS-1:0] rs;
    logic [NUM_ROWS-1:0] pat;
    logic [NUM_ROWS-1:0] pat_n;
    logic [FLOOR_W-1:0]  floor_q;
    logic [FLOOR_W-1:0]  floor_n;
    logic                multi;
    logic                key_hit;

    sync2 #(
        .W       (NUM_ROWS),
        .RST_VAL (ROW_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row),
        .q     (rs)
    );

`ifdef KEYPAD_MULTI_KEY_REJECT_EN
    assign multi = multi_low(rs);
`else
    assign multi = 1'b0;
`endif

    assign key_hit     = (rs != ROW_IDLE) && !multi;
    assign col         = ~(4'b0001 << c);
    assign floor       = floor_q;
    assign floor_valid = (state == VALID);

    // Saturating increment so the counter can never wrap.
    always_comb begin
        cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
    end

    // Next-state logic for scan, debounce, handshake and release.
    always_comb begin
        state_n = state;
        c_n     = c;
        cnt_n   = cnt;
        pat_n   = pat;
        floor_n = floor_q;
        unique case (state)
            SCAN: begin
                if (cnt >= SLOT_LAST) begin
                    cnt_n = '0;
                    if (key_hit) begin
                        state_n = DEBOUNCE;
                        pat_n   = rs;
                    end else begin
                        c_n = c + 2'd1;
                    end
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            DEBOUNCE: begin
                if (rs != pat) begin
                    state_n = SCAN;
                    c_n     = c + 2'd1;
                    cnt_n   = '0;
                end else if (cnt >= DB_LAST) begin
                    state_n = VALID;
                    floor_n = {c, row_index(pat)};
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            VALID: begin
                if (floor_ready) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                end
            end
            RELEASE: begin
                if (rs != ROW_IDLE) begin
                    cnt_n = '0;
                end else if (cnt >= DB_LAST) begin
                    state_n = SCAN;
                    c_n     = 2'd0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = SCAN;
                c_n     = 2'd0;
                cnt_n   = '0;
            end
        endcase
    end

    // State, column, counter and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SCAN;
            c       <= 2'd0;
            cnt     <= '0;
            pat     <= ROW_IDLE;
            floor_q <= '0;
        end else begin
            state   <= state_n;
            c       <= c_n;
            cnt     <= cnt_n;
            pat     <= pat_n;
            floor_q <= floor_n;
        end
    end

endmodule

// File: tb/tb_keypad_scan_lift.sv
// Directed-vector bench for keypad_scan_lift with SCAN_DIV=4, DEBOUNCE_CNT=8.
// A keypad model pulls the selected row pattern low while its column is driven.
module tb_keypad_scan_lift;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] floor;
    logic       floor_valid;
    logic       floor_ready = 1'b0;

    logic [3:0] drive_col = 4'hF;
    logic [3:0] pattern = 4'hF;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign row = (col == drive_col) ? pattern : 4'hF;

    keypad_scan_lift #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row         (row),
        .col         (col),
        .floor       (floor),
        .floor_valid (floor_valid),
        .floor_ready (floor_ready)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (col !== 4'b1110) begin
            miscompares++;
            $display("FAIL reset_col got %b want 1110", col);
        end
        vectors++;
        if (floor !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_floor got %h want 0", floor);
        end
        vectors++;
        if (floor_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid got %b want 0", floor_valid);
        end
    endtask

    task automatic test_scan();
        logic [3:0] one;
        logic [3:0] exp;
        one = 4'b0001;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            exp = ~(one << ((i / 4) % 4));
            vectors++;
            if (col !== exp || floor_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL scan_col[%0d] got col=%b valid=%b want col=%b valid=0",
                         i, col, floor_valid, exp);
            end
        end
    endtask

    task automatic test_press_ready();
        int n;
        logic [3:0] exp;
        floor_ready = 1'b1;
        drive_col = 4'b1011;
        pattern = 4'b1101;
        n = 0;
        while (floor_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (floor_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL press_timeout got valid=%b want 1", floor_valid);
        end
        vectors++;
        if (floor !== 4'h9 || col !== 4'b1011) begin
            miscompares++;
            $display("FAIL press_floor got floor=%h col=%b want floor=9 col=1011",
                     floor, col);
        end
        @(negedge clk);
        vectors++;
        if (floor_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL press_one_cycle got valid=%b want 0", floor_valid);
        end
        pattern = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp = (k < 10) ? 4'b1011 : 4'b1110;
            vectors++;
            if (col !== exp || floor_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL press_release[%0d] got col=%b valid=%b want col=%b valid=0",
                         k, col, floor_valid, exp);
            end
        end
    endtask

    task automatic test_ready_hold();
        int n;
        floor_ready = 1'b0;
        drive_col = 4'b1011;
        pattern = 4'b1101;
        n = 0;
        while (floor_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 50; k++) begin
            vectors++;
            if (floor_valid !== 1'b1 || floor !== 4'h9) begin
                miscompares++;
                $display("FAIL hold_stable[%0d] got valid=%b floor=%h want valid=1 floor=9",
                         k, floor_valid, floor);
            end
            @(negedge clk);
        end
        floor_ready = 1'b1;
        vectors++;
        if (floor_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_ready_cycle got valid=%b want 1", floor_valid);
        end
        @(negedge clk);
        vectors++;
        if (floor_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_handshake got valid=%b want 0", floor_valid);
        end
        pattern = 4'hF;
        n = 0;
        while (col !== 4'b1110 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (col !== 4'b1110) begin
            miscompares++;
            $display("FAIL hold_resume got col=%b want 1110", col);
        end
    endtask

    task automatic test_bounce();
        int n;
        logic [3:0] exp;
        floor_ready = 1'b1;
        drive_col = 4'b1101;
        pattern = 4'hF;
        n = 0;
        while (col === 4'b1101 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (col !== 4'b1101 && n < 40) begin
            @(negedge clk);
            n++;
        end
        pattern = 4'b1110;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) pattern = 4'hF;
            if (k == 4) pattern = 4'b1110;
            vectors++;
            if (floor_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL bounce_novalid[%0d] got valid=%b want 0", k, floor_valid);
            end
        end
        vectors++;
        if (col !== 4'b1011) begin
            miscompares++;
            $display("FAIL bounce_reject got col=%b want 1011", col);
        end
        n = 0;
        while (floor_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (floor_valid !== 1'b1 || floor !== 4'h4) begin
            miscompares++;
            $display("FAIL bounce_floor got valid=%b floor=%h want valid=1 floor=4",
                     floor_valid, floor);
        end
        @(negedge clk);
        pattern = 4'hF;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp = (k < 16) ? 4'b1101 : 4'b1110;
            vectors++;
            if (col !== exp || floor_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL bounce_release[%0d] got col=%b valid=%b want col=%b valid=0",
                         k, col, floor_valid, exp);
            end
            if (k == 5) pattern = 4'b1110;
            if (k == 6) pattern = 4'hF;
        end
    endtask

    task automatic test_multi();
        int n;
        int seen;
        floor_ready = 1'b1;
        drive_col = 4'b0111;
        pattern = 4'b0110;
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (floor_valid !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL multi_reject got %0d valid cycles want 0", seen);
        end
        pattern = 4'hF;
        n = 0;
        while (col !== 4'b1110 && n < 40) begin
            @(negedge clk);
            n++;
        end
`else
        seen = 0;
        n = 0;
        while (floor_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (floor_valid !== 1'b1 || floor !== 4'hC) begin
            miscompares++;
            $display("FAIL multi_lowest got valid=%b floor=%h want valid=1 floor=c",
                     floor_valid, floor);
        end
        @(negedge clk);
        pattern = 4'hF;
        n = 0;
        while (col !== 4'b1110 && n < 40) begin
            @(negedge clk);
            if (floor_valid !== 1'b0) seen++;
            n++;
        end
        vectors++;
        if (col !== 4'b1110 || seen != 0) begin
            miscompares++;
            $display("FAIL multi_resume got col=%b extra_valid=%0d want col=1110 extra_valid=0",
                     col, seen);
        end
`endif
    endtask

    task automatic test_reset_in_valid();
        int n;
        int seen;
        floor_ready = 1'b0;
        drive_col = 4'b1011;
        pattern = 4'b1101;
        n = 0;
        while (floor_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (floor_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rstv_reach got valid=%b want 1", floor_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (floor_valid !== 1'b0 || col !== 4'b1110 || floor !== 4'h0) begin
            miscompares++;
            $display("FAIL rstv_async got valid=%b col=%b floor=%h want valid=0 col=1110 floor=0",
                     floor_valid, col, floor);
        end
        pattern = 4'hF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (floor_valid !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL rstv_discard got %0d valid cycles want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_press_ready();
        test_ready_hold();
        test_bounce();
        test_multi();
        test_reset_in_valid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
